// File: rtl/cell_cfg_loader.sv
// -----------------------------------------------------------------------------
// cell_cfg_loader
//
// Serial configuration loader for an array of NUM_CELLS 4:1 data-select cells.
// Configuration bits arrive one at a time under a valid/ready handshake and
// are assembled in a shadow shift register. Once a complete frame has been
// received, it is copied to the parallel output bus in a single cycle, so the
// cells never see a partially loaded frame.
//
// Optional feature (compile-time macro CELL_CFG_PARITY_EN):
//   When defined, one even-parity bit follows the W data bits and is checked
//   in a CHECK state. A parity failure sets the sticky err flag and leaves the
//   active configuration unchanged. When the macro is undefined there is no
//   CHECK state and no parity register, and err is tied to 0.
//
// Ports:
//   clk        in   system clock, rising edge
//   CLR        in   asynchronous active-high reset (also clears cfg_out)
//   start      in   one-cycle request to begin loading a frame (IDLE only)
//   abort      in   cancel the load in progress; cfg_out is left untouched
//   cfg_bit    in   serial configuration data, first bit -> cfg_out[W-1]
//   cfg_valid  in   cfg_bit is valid this cycle
//   cfg_ready  out  loader accepts a bit this cycle
//   cfg_out    out  active configuration; cell k uses [4k+3:4k] = {d11,d10,d01,d00}
//   busy       out  high whenever the loader is not IDLE
//   done       out  one-cycle pulse on the cycle cfg_out is updated
//   err        out  sticky parity error (parity build only, else 0)
// -----------------------------------------------------------------------------
module cell_cfg_loader #(
    parameter int NUM_CELLS = 4
) (
    input  logic                   clk,
    input  logic                   CLR,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   cfg_bit,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    output logic [4*NUM_CELLS-1:0] cfg_out,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int W  = 4 * NUM_CELLS;
    localparam int CW = $clog2(W + 1);

`ifdef CELL_CFG_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd3
    } state_t;
`endif

    state_t          state_reg,   state_next;
    logic [W-1:0]    shadow_reg,  shadow_next;
    logic [CW-1:0]   cnt_reg,     cnt_next;
    logic [W-1:0]    cfg_out_reg, cfg_out_next;
    logic            done_reg,    done_next;
`ifdef CELL_CFG_PARITY_EN
    logic            par_reg,     par_next;
    logic            err_reg,     err_next;
`endif

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            state_reg   <= IDLE;
            shadow_reg  <= '0;
            cnt_reg     <= '0;
            cfg_out_reg <= '0;
            done_reg    <= 1'b0;
`ifdef CELL_CFG_PARITY_EN
            par_reg     <= 1'b0;
            err_reg     <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            shadow_reg  <= shadow_next;
            cnt_reg     <= cnt_next;
            cfg_out_reg <= cfg_out_next;
            done_reg    <= done_next;
`ifdef CELL_CFG_PARITY_EN
            par_reg     <= par_next;
            err_reg     <= err_next;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        shadow_next  = shadow_reg;
        cnt_next     = cnt_reg;
        cfg_out_next = cfg_out_reg;
        done_next    = 1'b0;
        cfg_ready    = 1'b0;
`ifdef CELL_CFG_PARITY_EN
        par_next     = par_reg;
        err_next     = err_reg;
`endif

        case (state_reg)
            IDLE: begin
                // abort has priority over a simultaneous start
                if (start && !abort) begin
                    state_next  = SHIFT;
                    cnt_next    = '0;
                    shadow_next = '0;
`ifdef CELL_CFG_PARITY_EN
                    par_next    = 1'b0;
                    err_next    = 1'b0;
`endif
                end
            end

            SHIFT: begin
                cfg_ready = 1'b1;
                if (abort) begin
                    // abort also wins over a final bit arriving this cycle
                    state_next  = IDLE;
                    cnt_next    = '0;
                    shadow_next = '0;
                end else if (cfg_valid) begin
                    shadow_next = {shadow_reg[W-2:0], cfg_bit};
                    cnt_next    = cnt_reg + CW'(1);
`ifdef CELL_CFG_PARITY_EN
                    par_next    = par_reg ^ cfg_bit;
`endif
                    if (cnt_reg == CW'(W - 1)) begin
`ifdef CELL_CFG_PARITY_EN
                        state_next = CHECK;
`else
                        state_next = COMMIT;
`endif
                    end
                end
            end

`ifdef CELL_CFG_PARITY_EN
            CHECK: begin
                cfg_ready = 1'b1;
                if (abort) begin
                    state_next  = IDLE;
                    cnt_next    = '0;
                    shadow_next = '0;
                end else if (cfg_valid) begin
                    // par_reg already holds the XOR of all data bits; the
                    // parity bit makes the total even on a good frame.
                    if (par_reg ^ cfg_bit) begin
                        state_next  = IDLE;
                        err_next    = 1'b1;
                        cnt_next    = '0;
                        shadow_next = '0;
                    end else begin
                        state_next  = COMMIT;
                    end
                end
            end
`endif

            COMMIT: begin
                // abort is deliberately not looked at here: the commit completes
                cfg_out_next = shadow_reg;
                done_next    = 1'b1;
                cnt_next     = '0;
                state_next   = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign cfg_out = cfg_out_reg;
    assign done    = done_reg;
    assign busy    = (state_reg != IDLE);

`ifdef CELL_CFG_PARITY_EN
    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cell_cfg_loader.sv
module tb_cell_cfg_loader;

    localparam int NC = 2;
    localparam int W  = 4 * NC;

    logic         clk = 1'b0;
    logic         CLR;
    logic         start;
    logic         abort;
    logic         cfg_bit;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_out;
    logic         busy;
    logic         done;
    logic         err;

    cell_cfg_loader #(.NUM_CELLS(NC)) dut (
        .clk       (clk),
        .CLR       (CLR),
        .start     (start),
        .abort     (abort),
        .cfg_bit   (cfg_bit),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_out   (cfg_out),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] data;
        int           last_cyc;
    } exp_t;

    exp_t         expq[$];
    logic [W-1:0] active_model = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every commit must match the oldest expected frame and arrive
    // exactly one cycle after its last accepted bit; between commits cfg_out
    // must hold the last committed value.
    always @(negedge clk) begin
        exp_t e;
        if (CLR) begin
            active_model = '0;
        end else if (done) begin
            if (expq.size() == 0) begin
                chk("done_unexpected", {31'd0, done}, 32'd0);
            end else begin
                e = expq.pop_front();
                chk("commit_cfg_out", {24'd0, cfg_out}, {24'd0, e.data});
                chk("done_latency", cyc, e.last_cyc + 1);
                chk("err_on_done", {31'd0, err}, 32'd0);
                active_model = e.data;
                $display("commit cfg_out=%h cell1=%h cell0=%h cyc=%0d",
                         cfg_out, cfg_out[7:4], cfg_out[3:0], cyc);
            end
        end else begin
            chk("cfg_out_stable", {24'd0, cfg_out}, {24'd0, active_model});
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("ready_in_shift", {31'd0, cfg_ready}, 32'd1);
    endtask

    // Send the first n bits of f (MSB first) with cfg_valid held high.
    task automatic send_bits(input logic [W-1:0] f, input int n);
        for (int k = 0; k < n; k++) begin
            cfg_valid = 1'b1;
            cfg_bit   = f[W-1-k];
            @(posedge clk); #1;
        end
        cfg_valid = 1'b0;
    endtask

    // Send a full frame (plus parity bit in the parity build), optionally
    // dropping cfg_valid for gap_len cycles after gap_after bits.
    task automatic send_frame(input logic [W-1:0] f, input logic par,
                              input int gap_after, input int gap_len,
                              output int last);
        last = 0;
        for (int k = 0; k < W; k++) begin
            cfg_valid = 1'b1;
            cfg_bit   = f[W-1-k];
            @(posedge clk); #1;
            last = cyc;
            if (k + 1 == gap_after) begin
                cfg_valid = 1'b0;
                cfg_bit   = ~cfg_bit;
                for (int g = 0; g < gap_len; g++) begin
                    chk("ready_in_gap", {31'd0, cfg_ready}, 32'd1);
                    @(posedge clk); #1;
                end
            end
        end
`ifdef CELL_CFG_PARITY_EN
        cfg_valid = 1'b1;
        cfg_bit   = par;
        @(posedge clk); #1;
        last = cyc;
`endif
        cfg_valid = 1'b0;
    endtask

    task automatic load(input logic [W-1:0] f, input logic par,
                        input int gap_after, input int gap_len);
        int last;
        exp_t e;
        do_start();
        send_frame(f, par, gap_after, gap_len, last);
        e.data     = f;
        e.last_cyc = last;
        expq.push_back(e);
        @(posedge clk); #1;
        chk("busy_after_commit", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        CLR       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        cfg_bit   = 1'b0;
        cfg_valid = 1'b0;
        #12;
        chk("rst_cfg_out", {24'd0, cfg_out}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, cfg_ready}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        @(posedge clk); #1;
        CLR = 1'b0;
        @(posedge clk); #1;

        // Basic load: 1,0,1,0,0,1,1,0 -> 8'hA6 (parity bit 0 is even)
        load(8'hA6, 1'b0, 0, 0);
        chk("load_a6", {24'd0, cfg_out}, 32'h0000_00A6);
        chk("cell1", {28'd0, cfg_out[7:4]}, 32'hA);
        chk("cell0", {28'd0, cfg_out[3:0]}, 32'h6);
        chk("err_after_good", {31'd0, err}, 32'd0);

        // Same stream, cfg_valid low for 3 cycles after bit 4
        load(8'h5B, 1'b1, 0, 0);
        load(8'hA6, 1'b0, 4, 3);
        chk("gap_a6", {24'd0, cfg_out}, 32'h0000_00A6);

        // Abort after 5 bits: no commit, back to IDLE
        do_start();
        send_bits(8'h3C, 5);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_ready", {31'd0, cfg_ready}, 32'd0);
        chk("abort_keep", {24'd0, cfg_out}, 32'h0000_00A6);

        // Abort arriving with the final data bit still wins
        do_start();
        send_bits(8'hFF, W - 1);
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
        abort     = 1'b1;
        @(posedge clk); #1;
        abort     = 1'b0;
        cfg_valid = 1'b0;
        chk("abort_last_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_last_keep", {24'd0, cfg_out}, 32'h0000_00A6);

        // start together with abort in IDLE is ignored
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle", {31'd0, busy}, 32'd0);

        // start during SHIFT must not restart the bit counter
        begin
            int   last;
            exp_t e;
            logic [W-1:0] f;
            f = 8'hC3;
            do_start();
            for (int k = 0; k < W; k++) begin
                cfg_valid = 1'b1;
                cfg_bit   = f[W-1-k];
                start     = (k == 3);
                @(posedge clk); #1;
                last = cyc;
            end
            start = 1'b0;
`ifdef CELL_CFG_PARITY_EN
            cfg_bit = 1'b0;
            @(posedge clk); #1;
            last = cyc;
`endif
            cfg_valid  = 1'b0;
            e.data     = f;
            e.last_cyc = last;
            expq.push_back(e);
            @(posedge clk); #1;
            chk("start_in_shift", {24'd0, cfg_out}, 32'h0000_00C3);
        end

`ifdef CELL_CFG_PARITY_EN
        // Parity: A6 with even parity commits; 3C with parity 1 fails
        load(8'hA6, 1'b0, 0, 0);
        chk("par_ok_cfg", {24'd0, cfg_out}, 32'h0000_00A6);
        chk("par_ok_err", {31'd0, err}, 32'd0);
        begin
            int last;
            do_start();
            send_frame(8'h3C, 1'b1, 0, 0, last);
        end
        chk("par_bad_err", {31'd0, err}, 32'd1);
        chk("par_bad_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("par_bad_keep", {24'd0, cfg_out}, 32'h0000_00A6);
        chk("err_sticky", {31'd0, err}, 32'd1);
        do_start();
        chk("err_clear_start", {31'd0, err}, 32'd0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
`else
        chk("err_tied_low", {31'd0, err}, 32'd0);
`endif

        // Asynchronous CLR mid-SHIFT after 3 bits
        do_start();
        send_bits(8'hE7, 3);
        #2;
        CLR = 1'b1;
        #1;
        chk("clr_cfg_out", {24'd0, cfg_out}, 32'd0);
        chk("clr_busy", {31'd0, busy}, 32'd0);
        chk("clr_ready", {31'd0, cfg_ready}, 32'd0);
        @(negedge clk); #1;
        CLR = 1'b0;
        @(posedge clk); #1;

        // Recovery after CLR
        load(8'h96, 1'b0, 0, 0);
        chk("recover", {24'd0, cfg_out}, 32'h0000_0096);

        // Drain pending expectations with a bounded wait
        for (int i = 0; i < 50 && expq.size() != 0; i++) @(posedge clk);
        chk("pending_timeout", expq.size(), 32'd0);
        @(negedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
